// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline stall/flush/redirect control with saturating per-cause stall counters
module hazard_ctrl_unit #(
    parameter int NUM_STAGES  = 5,
    parameter int NUM_MC      = 1,
    parameter int REDIR_STAGE = 2,
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    input  logic [NUM_MC-1:0]     mc_start,
    input  logic [NUM_MC-1:0]     mc_resp,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_target,
    input  logic                  ex_is_load,
    input  logic [4:0]            ex_rd,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  perf_clear,
    output logic                  load_pc,
    output logic                  pc_sel,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [NUM_STAGES-2:0] load_reg,
    output logic [NUM_STAGES-2:0] flush_reg,
    output logic [CNT_W-1:0]      perf_backend,
    output logic [CNT_W-1:0]      perf_redirect,
    output logic [CNT_W-1:0]      perf_loaduse,
    output logic [CNT_W-1:0]      perf_imiss
);
    localparam int NR = NUM_STAGES - 1;
    localparam logic [NR-1:0] REDIR_MASK = NR'((1 << REDIR_STAGE) - 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [3:0]      inc;
    logic [CNT_W-1:0] cnt [4];
    logic            backend_stall, loaduse;

    assign backend_stall = (dmem_req & ~dmem_resp) | |(mc_start & ~mc_resp);
    assign loaduse = ex_is_load & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign redirect_pc   = (state == DRAIN) ? tgt_q : redirect_target;
    assign perf_backend  = cnt[0];
    assign perf_redirect = cnt[1];
    assign perf_loaduse  = cnt[2];
    assign perf_imiss    = cnt[3];

    // Redirect FSM state and the branch target held while a stale fetch drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            tgt_q <= '0;
        end else begin
            state <= state_d;
            tgt_q <= tgt_d;
        end
    end

    // Strict-priority cause selection: backend > redirect/drain > load-use > imiss
    always_comb begin
        state_d   = state;
        tgt_d     = tgt_q;
        inc       = '0;
        load_pc   = 1'b1;
        pc_sel    = 1'b0;
        load_reg  = '1;
        flush_reg = '0;
        if (backend_stall) begin
            load_reg = '0;
            load_pc  = (state == DRAIN) & inst_resp;
            pc_sel   = state == DRAIN;
            state_d  = (state == DRAIN && inst_resp) ? RUN : state;
            inc[0]   = 1'b1;
        end else if (state == DRAIN) begin
            flush_reg[0] = 1'b1;
            load_pc      = inst_resp;
            pc_sel       = 1'b1;
            state_d      = inst_resp ? RUN : DRAIN;
            tgt_d        = redirect ? redirect_target : tgt_q;
            inc[1]       = 1'b1;
        end else if (redirect) begin
            flush_reg = REDIR_MASK;
            load_pc   = inst_resp;
            pc_sel    = inst_resp;
            state_d   = inst_resp ? RUN : DRAIN;
            tgt_d     = inst_resp ? tgt_q : redirect_target;
            inc[1]    = 1'b1;
        end else if (loaduse) begin
            load_pc      = 1'b0;
            load_reg[0]  = 1'b0;
            flush_reg[1] = 1'b1;
            inc[2]       = 1'b1;
        end else if (!inst_resp) begin
            load_pc      = 1'b0;
            flush_reg[0] = 1'b1;
            inc[3]       = 1'b1;
        end
        if (rst) begin
            load_pc   = 1'b0;
            pc_sel    = 1'b0;
            load_reg  = '0;
            flush_reg = '1;
        end
    end

    // Saturating stall counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (perf_clear) cnt[i] <= '0;
                else if (inc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed stimulus checked against a cause-table model every cycle
module tb_hazard_ctrl_unit;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_resp, dmem_req, dmem_resp, redirect, ex_is_load;
    logic        id_use_rs1, id_use_rs2, perf_clear;
    logic [1:0]  mc_start, mc_resp;
    logic [31:0] redirect_target;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        load_pc, pc_sel;
    logic [31:0] redirect_pc;
    logic [3:0]  load_reg, flush_reg;
    logic [CW-1:0] perf_backend, perf_redirect, perf_loaduse, perf_imiss;

    int errors = 0;
    int checks = 0;

    hazard_ctrl_unit #(.NUM_STAGES(5), .NUM_MC(2), .REDIR_STAGE(2), .XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .inst_resp(inst_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .mc_start(mc_start), .mc_resp(mc_resp), .redirect(redirect), .redirect_target(redirect_target),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .perf_clear(perf_clear),
        .load_pc(load_pc), .pc_sel(pc_sel), .redirect_pc(redirect_pc), .load_reg(load_reg),
        .flush_reg(flush_reg), .perf_backend(perf_backend), .perf_redirect(perf_redirect),
        .perf_loaduse(perf_loaduse), .perf_imiss(perf_imiss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending-redirect flag, held target, per-cause counts
    bit          m_drain;
    logic [31:0] m_tgt;
    int          m_cnt [4];

    always @(negedge clk) begin
        int cause;
        bit bs, lu, was_drain;
        logic        e_lpc, e_sel;
        logic [3:0]  e_lreg, e_freg;
        if (rst) begin
            m_drain = 0;
            m_tgt = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            chk("m_rst_load_pc", load_pc, 0);
            chk("m_rst_pc_sel", pc_sel, 0);
            chk("m_rst_load_reg", load_reg, 4'h0);
            chk("m_rst_flush_reg", flush_reg, 4'hf);
        end else begin
            bs = (dmem_req && !dmem_resp) || ((mc_start & ~mc_resp) != 0);
            lu = ex_is_load && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            cause = bs ? 0 : (m_drain || redirect) ? 1 : lu ? 2 : !inst_resp ? 3 : 4;
            e_lpc = 1; e_sel = 0; e_lreg = 4'hf; e_freg = 4'h0;
            if (cause == 0) begin
                e_lreg = 0; e_lpc = m_drain && inst_resp; e_sel = m_drain;
            end else if (cause == 1) begin
                e_freg = m_drain ? 4'b0001 : 4'b0011;
                e_lpc = inst_resp;
                e_sel = m_drain || inst_resp;
            end else if (cause == 2) begin
                e_lpc = 0; e_lreg = 4'b1110; e_freg = 4'b0010;
            end else if (cause == 3) begin
                e_lpc = 0; e_freg = 4'b0001;
            end
            chk("m_load_pc", load_pc, e_lpc);
            chk("m_pc_sel", pc_sel, e_sel);
            chk("m_load_reg", load_reg, e_lreg);
            chk("m_flush_reg", flush_reg, e_freg);
            chk("m_redirect_pc", redirect_pc, m_drain ? m_tgt : redirect_target);
            was_drain = m_drain;
            if (was_drain && inst_resp) m_drain = 0;
            else if (cause == 1 && was_drain && redirect) m_tgt = redirect_target;
            if (cause == 1 && !was_drain && !inst_resp) begin
                m_drain = 1;
                m_tgt = redirect_target;
            end
        end
        chk("m_perf_backend", perf_backend, m_cnt[0]);
        chk("m_perf_redirect", perf_redirect, m_cnt[1]);
        chk("m_perf_loaduse", perf_loaduse, m_cnt[2]);
        chk("m_perf_imiss", perf_imiss, m_cnt[3]);
        if (!rst) begin
            if (perf_clear) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            else if (cause < 4 && m_cnt[cause] < CMAX) m_cnt[cause]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_resp = 1; dmem_req = 0; dmem_resp = 0; redirect = 0; ex_is_load = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; perf_clear = 0; mc_start = 0; mc_resp = 0;
        redirect_target = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        #1;
        chk("rst_flush_reg", flush_reg, 4'hf);
        chk("rst_load_pc", load_pc, 0);
        repeat (2) tick();
        rst = 0;
        repeat (10) tick();
        chk("run_load_pc", load_pc, 1);
        chk("run_load_reg", load_reg, 4'hf);
        chk("run_flush_reg", flush_reg, 0);
        chk("run_imiss", perf_imiss, 0);
        // load-use on rs2
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #1;
        chk("lu_load_pc", load_pc, 0);
        chk("lu_load_reg", load_reg, 4'b1110);
        chk("lu_flush_reg", flush_reg, 4'b0010);
        tick();
        ex_rd = 0; id_rs2 = 0;
        #1;
        chk("lu_cnt", perf_loaduse, 1);
        chk("lu_x0_load_pc", load_pc, 1);
        chk("lu_x0_flush", flush_reg, 0);
        tick();
        idle();
        // redirect with fetch complete
        redirect = 1; redirect_target = 32'h400;
        #1;
        chk("rd_load_pc", load_pc, 1);
        chk("rd_pc_sel", pc_sel, 1);
        chk("rd_pc", redirect_pc, 32'h400);
        chk("rd_flush", flush_reg, 4'b0011);
        tick();
        redirect = 0; redirect_target = 32'h123;
        #1;
        chk("rd_stay_run", pc_sel, 0);
        chk("rd_cnt", perf_redirect, 1);
        tick();
        // redirect with stale fetch: drain
        redirect = 1; redirect_target = 32'h800; inst_resp = 0;
        tick();
        redirect = 0; redirect_target = 0;
        repeat (2) begin
            #1;
            chk("dr_flush", flush_reg, 4'b0001);
            chk("dr_load_pc", load_pc, 0);
            chk("dr_pc", redirect_pc, 32'h800);
            tick();
        end
        inst_resp = 1;
        #1;
        chk("dr_end_load_pc", load_pc, 1);
        chk("dr_end_pc_sel", pc_sel, 1);
        chk("dr_end_pc", redirect_pc, 32'h800);
        tick();
        chk("dr_back_run", pc_sel, 0);
        chk("dr_cnt", perf_redirect, 5);
        // backend stall masks redirect and load-use
        dmem_req = 1; redirect = 1; redirect_target = 32'hc00;
        ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        repeat (5) begin
            #1;
            chk("be_load_reg", load_reg, 0);
            chk("be_load_pc", load_pc, 0);
            tick();
        end
        chk("be_cnt", perf_backend, 5);
        chk("be_rd_cnt", perf_redirect, 5);
        chk("be_lu_cnt", perf_loaduse, 1);
        dmem_resp = 1;
        #1;
        chk("be_rd_pc_sel", pc_sel, 1);
        chk("be_rd_pc", redirect_pc, 32'hc00);
        tick();
        idle();
        mc_start = 2'b10; mc_resp = 2'b01;
        tick();
        idle();
        chk("mc_cnt", perf_backend, 6);
        // imiss saturation and clear
        inst_resp = 0;
        repeat (20) tick();
        chk("imiss_sat", perf_imiss, 15);
        perf_clear = 1;
        tick();
        perf_clear = 0;
        chk("clr_imiss", perf_imiss, 0);
        chk("clr_backend", perf_backend, 0);
        // reset in the middle of a drain
        redirect = 1; redirect_target = 32'h900;
        tick();
        redirect = 0;
        tick();
        rst = 1;
        #1;
        chk("rst_dr_flush", flush_reg, 4'hf);
        chk("rst_dr_pc_sel", pc_sel, 0);
        tick();
        rst = 0; inst_resp = 1; redirect_target = 32'h55;
        #1;
        chk("rst_dr_run", pc_sel, 0);
        chk("rst_dr_pc", redirect_pc, 32'h55);
        chk("rst_dr_load_pc", load_pc, 1);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
